// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Two-port round-robin arbiter and sequencer for a single-port synchronous
//   memory. Each requester hands over a read or write with a valid/ready
//   handshake. Requests are serialised onto the shared wr/rd/addr/data bus,
//   and read data goes back to the requester that asked for it.
//   Every transaction runs IDLE -> ACCESS (one cycle). A read then also
//   spends one cycle in RESP before the FSM returns to IDLE.
//
// Ports:
//   clk            single clock, all state changes on posedge
//   rst_n          asynchronous active-low reset
//   reqN_valid     requester N has a request (N = 0, 1)
//   reqN_we        1 = write, 0 = read
//   reqN_addr      request address
//   reqN_wdata     write data (ignored for reads)
//   reqN_ready     request accepted this cycle (combinational, IDLE only)
//   reqN_rvalid    one-cycle pulse, reqN_rdata holds the read result
//   reqN_rdata     read data register, held until that port's next read
//   mem_wr         memory write strobe (registered)
//   mem_rd         memory read enable (registered)
//   mem_addr       memory address (registered)
//   mem_data       bidirectional data, driven only while mem_wr = 1
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [AWIDTH-1:0] req0_addr,
    input  logic [DWIDTH-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DWIDTH-1:0] req0_rdata,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [AWIDTH-1:0] req1_addr,
    input  logic [DWIDTH-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DWIDTH-1:0] req1_rdata,

    output logic              mem_wr,
    output logic              mem_rd,
    output logic [AWIDTH-1:0] mem_addr,
    inout  wire  [DWIDTH-1:0] mem_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last;      // id of the most recently granted requester
    logic               r_we;        // latched request type
    logic               r_id;        // latched requester id
    logic [DWIDTH-1:0]  r_wdata;
    logic [AWIDTH-1:0]  r_mem_addr;
    logic               r_mem_wr;
    logic               r_mem_rd;

    logic               w_grant0;
    logic               w_grant1;
    logic               w_hs;
    logic               w_sel_we;
    logic [AWIDTH-1:0]  w_sel_addr;
    logic [DWIDTH-1:0]  w_sel_wdata;
    logic               w_rd_done;   // closing edge of a read ACCESS cycle

    // Round-robin: a lone requester always wins; on contention the requester
    // that was not granted last wins.
    assign w_grant0 = req0_valid && (!req1_valid ||  r_last);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last);

    assign req0_ready = (r_state == S_IDLE) && w_grant0;
    assign req1_ready = (r_state == S_IDLE) && w_grant1;
    assign w_hs       = req0_ready || req1_ready;

    // The two grants are exclusive, so req1_ready alone selects the source.
    assign w_sel_we    = req1_ready ? req1_we    : req0_we;
    assign w_sel_addr  = req1_ready ? req1_addr  : req0_addr;
    assign w_sel_wdata = req1_ready ? req1_wdata : req0_wdata;

    assign w_rd_done = (r_state == S_ACCESS) && !r_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_id       <= 1'b0;
            r_wdata    <= '0;
            r_mem_addr <= '0;
            r_mem_wr   <= 1'b0;
            r_mem_rd   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_id       <= req1_ready;
                        r_last     <= req1_ready;
                        r_we       <= w_sel_we;
                        r_wdata    <= w_sel_wdata;
                        r_mem_addr <= w_sel_addr;
                        // Strobes are registered here so they are glitch-free
                        // for the whole ACCESS cycle.
                        r_mem_wr   <= w_sel_we;
                        r_mem_rd   <= !w_sel_we;
                        r_state    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_mem_wr <= 1'b0;
                    r_mem_rd <= 1'b0;
                    r_state  <= r_we ? S_IDLE : S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Per-port read-return registers. The memory drives mem_data during the
    // read ACCESS cycle, and the value is captured at its closing edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic              r_rvalid;
            logic [DWIDTH-1:0] r_rdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rvalid <= 1'b0;
                    r_rdata  <= '0;
                end else begin
                    r_rvalid <= w_rd_done && (r_id == 1'(gi));
                    if (w_rd_done && (r_id == 1'(gi))) begin
                        r_rdata <= mem_data;
                    end
                end
            end
        end
    endgenerate

    assign req0_rvalid = g_port[0].r_rvalid;
    assign req0_rdata  = g_port[0].r_rdata;
    assign req1_rvalid = g_port[1].r_rvalid;
    assign req1_rdata  = g_port[1].r_rdata;

    assign mem_wr   = r_mem_wr;
    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;

    // Drive the bus only during a write ACCESS cycle. In every other cycle the
    // bus is released, which includes every cycle where mem_rd = 1.
    assign mem_data = r_mem_wr ? r_wdata : {DWIDTH{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Purpose:
//   Directed self-checking bench for mem_arbiter. It contains a behavioural
//   single-port memory. That memory drives the data bus during reads and drives
//   an idle pattern whenever nobody else should drive it, which lets an
//   unwanted drive from the arbiter show up as a corrupted bus value.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam logic [DW-1:0] IDLE_PAT = 8'hC3;

    logic          clk;
    logic          rst_n;
    logic          req0_valid, req0_we, req0_ready, req0_rvalid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_rdata;
    logic          req1_valid, req1_we, req1_ready, req1_rvalid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_rdata;
    logic          mem_wr, mem_rd;
    logic [AW-1:0] mem_addr;
    wire  [DW-1:0] mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_we     (req0_we),
        .req0_addr   (req0_addr),
        .req0_wdata  (req0_wdata),
        .req0_ready  (req0_ready),
        .req0_rvalid (req0_rvalid),
        .req0_rdata  (req0_rdata),
        .req1_valid  (req1_valid),
        .req1_we     (req1_we),
        .req1_addr   (req1_addr),
        .req1_wdata  (req1_wdata),
        .req1_ready  (req1_ready),
        .req1_rvalid (req1_rvalid),
        .req1_rdata  (req1_rdata),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: synchronous write, combinational read drive.
    logic [DW-1:0] mem_arr [32];
    logic          tb_en;
    logic [DW-1:0] tb_drv;

    initial begin
        for (int i = 0; i < 32; i++) mem_arr[i] = '0;
    end

    always @(posedge clk) begin
        if (mem_wr) mem_arr[mem_addr] <= mem_data;
    end

    always_comb begin
        tb_en  = !mem_wr;
        tb_drv = mem_rd ? mem_arr[mem_addr] : IDLE_PAT;
    end
    assign mem_data = tb_en ? tb_drv : 'z;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bus discipline, checked on every cycle.
    always @(negedge clk) begin
        check("wr_rd_exclusive", {31'd0, mem_wr && mem_rd}, 32'd0);
        if (!mem_wr) check("bus_not_driven", {24'd0, mem_data}, {24'd0, tb_drv});
    end

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
        end
    endtask

    // Run one transaction from port p. The caller must be at a negedge with
    // the FSM idle. For a read, d is the expected data. The task returns at the
    // negedge of the first cycle in which a new handshake is allowed.
    task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        int waited;
        logic rdy;
        set_req(p, 1'b1, we, a, we ? d : 8'h00);
        waited = 0;
        #1;
        rdy = (p == 0) ? req0_ready : req1_ready;
        while (!rdy && waited < 8) begin
            @(negedge clk); #1; waited++;
            rdy = (p == 0) ? req0_ready : req1_ready;
        end
        check("grant_in_time", {31'd0, rdy}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        set_req(p, 1'b0, 1'b0, '0, '0);
        check("access_addr", {27'd0, mem_addr}, {27'd0, a});
        if (we) begin
            check("wr_strobe_c1", {31'd0, mem_wr}, 32'd1);
            check("wr_data_c1", {24'd0, mem_data}, {24'd0, d});
            @(negedge clk);
            check("wr_strobe_c2", {31'd0, mem_wr}, 32'd0);
            $display("port%0d write addr=%0d data=%02h", p, a, d);
        end else begin
            check("rd_strobe_c1", {31'd0, mem_rd}, 32'd1);
            check("rd_no_wr_c1", {31'd0, mem_wr}, 32'd0);
            @(negedge clk);
            check("rvalid_own", {31'd0, (p == 0) ? req0_rvalid : req1_rvalid}, 32'd1);
            check("rvalid_other", {31'd0, (p == 0) ? req1_rvalid : req0_rvalid}, 32'd0);
            check("rdata", {24'd0, (p == 0) ? req0_rdata : req1_rdata}, {24'd0, d});
            @(negedge clk);
            check("rvalid_pulse", {31'd0, (p == 0) ? req0_rvalid : req1_rvalid}, 32'd0);
            $display("port%0d read  addr=%0d data=%02h", p, a, (p == 0) ? req0_rdata : req1_rdata);
        end
    endtask

    initial begin
        int n0, n1, g, waited;
        rst_n = 1'b0;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", {31'd0, req0_ready}, 32'd0);
        check("rst_ready1", {31'd0, req1_ready}, 32'd0);
        check("rst_rvalid", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
        check("rst_rdata0", {24'd0, req0_rdata}, 32'd0);
        check("rst_rdata1", {24'd0, req1_rdata}, 32'd0);
        check("rst_mem_ctl", {30'd0, mem_wr, mem_rd}, 32'd0);
        check("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        check("rst_bus_z", {24'd0, mem_data}, {24'd0, IDLE_PAT});
        $display("reset checked");
        rst_n = 1'b1;
        @(negedge clk);

        // First contended grant goes to requester 0
        set_req(0, 1'b1, 1'b0, 5'd0, 8'h00);
        set_req(1, 1'b1, 1'b0, 5'd0, 8'h00);
        #1;
        check("first_grant0", {31'd0, req0_ready}, 32'd1);
        check("first_grant1", {31'd0, req1_ready}, 32'd0);
        $display("first contended grant: ready0=%0b ready1=%0b", req0_ready, req1_ready);
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);

        // Single write/read
        issue(0, 1'b1, 5'd3, 8'hA5);
        issue(0, 1'b0, 5'd3, 8'hA5);
        issue(1, 1'b1, 5'd4, 8'h44);      // leaves the pointer at requester 1

        // Contention: 4 writes each, grants must alternate 0,1,0,1...
        set_req(0, 1'b1, 1'b1, 5'd1, 8'h11);
        set_req(1, 1'b1, 1'b1, 5'd2, 8'h22);
        n0 = 0; n1 = 0;
        for (int k = 0; k < 8; k++) begin
            waited = 0;
            #1;
            while (!(req0_ready || req1_ready) && waited < 8) begin
                @(negedge clk); #1; waited++;
            end
            check("cont_one_ready", {31'd0, req0_ready ^ req1_ready}, 32'd1);
            g = req1_ready ? 1 : 0;
            check("cont_grant", g, k % 2);
            $display("contention grant %0d -> port%0d", k, g);
            @(posedge clk);
            @(negedge clk);
            check("cont_wr", {31'd0, mem_wr}, 32'd1);
            if (g == 1) n1++; else n0++;
            if (n0 == 4) req0_valid = 1'b0;
            if (n1 == 4) req1_valid = 1'b0;
            @(negedge clk);
        end
        issue(1, 1'b0, 5'd2, 8'h22);
        issue(0, 1'b0, 5'd1, 8'h11);
        check("rdata1_hold", {24'd0, req1_rdata}, 32'h22);

        // Cross-port coherence: req1 write wins (pointer at 0), then req0 reads it
        set_req(1, 1'b1, 1'b1, 5'd31, 8'h3C);
        set_req(0, 1'b1, 1'b0, 5'd31, 8'h00);
        #1;
        check("coh_grant1", {30'd0, req1_ready, req0_ready}, 32'h2);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        check("coh_wr", {31'd0, mem_wr}, 32'd1);
        check("coh_wr_data", {24'd0, mem_data}, 32'h3C);
        check("coh_no_ready_busy", {31'd0, req0_ready}, 32'd0);
        @(negedge clk);
        #1;
        check("coh_grant0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        check("coh_rd", {31'd0, mem_rd}, 32'd1);
        @(negedge clk);
        check("coh_rvalid", {31'd0, req0_rvalid}, 32'd1);
        check("coh_rdata", {24'd0, req0_rdata}, 32'h3C);
        check("coh_rdata1_hold", {24'd0, req1_rdata}, 32'h22);
        $display("coherence read addr=31 data=%02h", req0_rdata);
        @(negedge clk);

        // Reset in the middle of a write ACCESS cycle
        set_req(0, 1'b1, 1'b1, 5'd7, 8'hFF);
        #1;
        check("mid_grant", {31'd0, req0_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        check("mid_wr", {31'd0, mem_wr}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_wr_cut", {31'd0, mem_wr}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rdata0_clr", {24'd0, req0_rdata}, 32'd0);
        $display("reset during write to addr 7");
        issue(0, 1'b0, 5'd7, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
